// File: rtl/taxi_axil_regfile_if.sv
// AXI4-lite bus bundle shared by the register file and its masters.
// Write (AW/W/B) and read (AR/R) halves have separate modports so each can be bound independently.
interface taxi_axil_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int STRB_W   = DATA_W / 8,
    parameter int AWUSER_W = 1,
    parameter int WUSER_W  = 1,
    parameter int BUSER_W  = 1,
    parameter int ARUSER_W = 1,
    parameter int RUSER_W  = 1
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic [AWUSER_W-1:0] awuser;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
    logic [WUSER_W-1:0]  wuser;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic [BUSER_W-1:0]  buser;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic [ARUSER_W-1:0] aruser;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic [RUSER_W-1:0]  ruser;
    logic                rvalid;
    logic                rready;

    modport wr_slv (
        input  awaddr, awprot, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wuser, wvalid,
        output wready,
        output bresp, buser, bvalid,
        input  bready
    );

    modport rd_slv (
        input  araddr, arprot, aruser, arvalid,
        output arready,
        output rdata, rresp, ruser, rvalid,
        input  rready
    );

    modport wr_mst (
        output awaddr, awprot, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wuser, wvalid,
        input  wready,
        input  bresp, buser, bvalid,
        output bready
    );

    modport rd_mst (
        output araddr, arprot, aruser, arvalid,
        input  arready,
        input  rdata, rresp, ruser, rvalid,
        output rready
    );
endinterface

// File: rtl/taxi_axil_regfile.sv
// AXI4-lite slave exposing REG_COUNT byte-writable registers with per-register access strobes.
// Write and read paths are independent two-state FSMs; AW and W may arrive in any order.
module taxi_axil_regfile #(
    parameter int REG_COUNT = 16,
    // Register width; must equal the DATA_W of the connected interface.
    parameter int DATA_W = 32,
    parameter logic [REG_COUNT*DATA_W-1:0] REG_RESET = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    taxi_axil_if.wr_slv                 s_axil_wr,
    taxi_axil_if.rd_slv                 s_axil_rd,
    output logic [REG_COUNT*DATA_W-1:0] reg_q,
    output logic [REG_COUNT-1:0]        reg_wr_stb,
    output logic [REG_COUNT-1:0]        reg_rd_stb
);
    localparam int ADDR_W   = s_axil_wr.ADDR_W;
    localparam int STRB_W   = s_axil_wr.STRB_W;
    localparam int ADDR_LSB = $clog2(STRB_W);
    // One spare bit so REG_COUNT itself is representable for the range compare.
    localparam int IDX_W    = ADDR_W + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    logic [REG_COUNT-1:0][DATA_W-1:0] regs_q, regs_d;

    wr_state_t            wr_state_q, wr_state_d;
    logic                 aw_held_q, aw_held_d;
    logic                 w_held_q, w_held_d;
    logic [ADDR_W-1:0]    awaddr_q, awaddr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic [REG_COUNT-1:0] wr_stb_q, wr_stb_d;

    rd_state_t            rd_state_q, rd_state_d;
    logic                 rvalid_q, rvalid_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [REG_COUNT-1:0] rd_stb_q, rd_stb_d;

    logic                 awready, wready, arready;
    logic                 aw_hs, w_hs, ar_hs, wr_commit;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [STRB_W-1:0]    wr_strb;
    logic [IDX_W-1:0]     wr_idx, rd_idx;
    logic                 wr_in_range, rd_in_range;

    // Readies are gated by rst_n so they read 0 during reset and 1 the first cycle after.
    assign awready = (wr_state_q == WR_IDLE) && !aw_held_q && rst_n;
    assign wready  = (wr_state_q == WR_IDLE) && !w_held_q && rst_n;
    assign arready = (rd_state_q == RD_IDLE) && rst_n;

    assign aw_hs = s_axil_wr.awvalid && awready;
    assign w_hs  = s_axil_wr.wvalid && wready;
    assign ar_hs = s_axil_rd.arvalid && arready;

    assign wr_addr     = aw_hs ? s_axil_wr.awaddr : awaddr_q;
    assign wr_data     = w_hs ? s_axil_wr.wdata : wdata_q;
    assign wr_strb     = w_hs ? s_axil_wr.wstrb : wstrb_q;
    assign wr_idx      = IDX_W'(wr_addr >> ADDR_LSB);
    assign wr_in_range = wr_idx < IDX_W'(REG_COUNT);
    assign wr_commit   = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign rd_idx      = IDX_W'(s_axil_rd.araddr >> ADDR_LSB);
    assign rd_in_range = rd_idx < IDX_W'(REG_COUNT);

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_stb_d   = '0;
        regs_d     = regs_q;
        if (wr_state_q == WR_IDLE) begin
            if (wr_commit) begin
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
                bvalid_d   = 1'b1;
                bresp_d    = wr_in_range ? RESP_OKAY : RESP_DECERR;
                wr_state_d = WR_RESP;
                for (int i = 0; i < REG_COUNT; i++) begin
                    if (wr_idx == IDX_W'(i)) begin
                        wr_stb_d[i] = 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                        end
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axil_wr.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axil_wr.wdata;
                    wstrb_d  = s_axil_wr.wstrb;
                end
            end
        end else if (s_axil_wr.bready) begin
            bvalid_d   = 1'b0;
            wr_state_d = WR_IDLE;
        end
    end

    // Read data comes from regs_q, so a write committing on the same edge is not visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        rd_stb_d   = '0;
        if (rd_state_q == RD_IDLE) begin
            if (ar_hs) begin
                rvalid_d   = 1'b1;
                rresp_d    = rd_in_range ? RESP_OKAY : RESP_DECERR;
                rdata_d    = '0;
                rd_state_d = RD_RESP;
                for (int i = 0; i < REG_COUNT; i++) begin
                    if (rd_idx == IDX_W'(i)) begin
                        rdata_d     = regs_q[i];
                        rd_stb_d[i] = 1'b1;
                    end
                end
            end
        end else if (s_axil_rd.rready) begin
            rvalid_d   = 1'b0;
            rd_state_d = RD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= REG_RESET;
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_stb_q   <= '0;
            rd_state_q <= RD_IDLE;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            rd_stb_q   <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_stb_q   <= wr_stb_d;
            rd_state_q <= rd_state_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_stb_q   <= rd_stb_d;
        end
    end

    assign s_axil_wr.awready = awready;
    assign s_axil_wr.wready  = wready;
    assign s_axil_wr.bvalid  = bvalid_q;
    assign s_axil_wr.bresp   = bresp_q;
    assign s_axil_wr.buser   = '0;

    assign s_axil_rd.arready = arready;
    assign s_axil_rd.rvalid  = rvalid_q;
    assign s_axil_rd.rresp   = rresp_q;
    assign s_axil_rd.rdata   = rdata_q;
    assign s_axil_rd.ruser   = '0;

    assign reg_q      = regs_q;
    assign reg_wr_stb = wr_stb_q;
    assign reg_rd_stb = rd_stb_q;

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_wr.awprot, s_axil_wr.awuser, s_axil_wr.wuser,
                             s_axil_rd.arprot, s_axil_rd.aruser};
endmodule
